// File: rtl/vc_input_block_v2.sv
// Router input stage: per-port, per-VC flit FIFOs with packet FSMs (IDLE/VA/ACTIVE),
// VA/SA request generation, registered crossbar flit and selectable upstream flow control.
module vc_input_block_v2 #(
    parameter int PORT_NUM         = 5,
    parameter int VC_NUM           = 2,
    parameter int BUFFER_SIZE      = 8,
    parameter int FLIT_WIDTH       = 64,
    parameter int CREDIT_MODE      = 1,
    parameter int ON_OFF_THRESHOLD = 2,
    localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_NUM*FLIT_WIDTH-1:0]   flit_i,
    input  logic [PORT_NUM-1:0]              valid_i,
    input  logic [PORT_NUM*VCW-1:0]          vc_id_i,
    input  logic [PORT_NUM*VC_NUM-1:0]       vc_grant_i,
    input  logic [PORT_NUM*VC_NUM*VCW-1:0]   vc_new_i,
    input  logic [PORT_NUM-1:0]              sw_grant_i,
    input  logic [PORT_NUM*VCW-1:0]          sw_vc_sel_i,
    output logic [PORT_NUM*FLIT_WIDTH-1:0]   flit_o,
    output logic [PORT_NUM-1:0]              flit_valid_o,
    output logic [PORT_NUM*VC_NUM-1:0]       vc_request_o,
    output logic [PORT_NUM*VC_NUM-1:0]       switch_request_o,
    output logic [PORT_NUM*VC_NUM*3-1:0]     out_port_o,
    output logic [PORT_NUM*VC_NUM*VCW-1:0]   downstream_vc_o,
    output logic [PORT_NUM*VC_NUM-1:0]       credit_o,
    output logic [PORT_NUM*VC_NUM-1:0]       vc_allocatable_o,
    output logic [PORT_NUM*VC_NUM-1:0]       error_o
);
    localparam int NVC   = PORT_NUM * VC_NUM;
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] TYPE_HEAD     = 2'b00;
    localparam logic [1:0] TYPE_TAIL     = 2'b10;
    localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

    logic [FLIT_WIDTH-1:0] head_flit [NVC];
    logic [NVC-1:0]        sw_pop;

    genvar gi;
    generate
        for (gi = 0; gi < NVC; gi++) begin : g_vc
            localparam int P = gi / VC_NUM;
            localparam int V = gi % VC_NUM;

            logic [FLIT_WIDTH-1:0] mem [BUFFER_SIZE];
            logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            vc_state_t             state_reg, state_next;
            logic [2:0]            out_port_reg;
            logic [VCW-1:0]        dvc_reg;
            logic                  error_reg;
            logic                  empty, full, push, push_ok, pop, discard;
            logic                  granted, bad_grant, is_head, is_last;
            logic [1:0]            head_type;

            assign head_flit[gi] = mem[rd_ptr_reg];
            assign head_type     = head_flit[gi][FLIT_WIDTH-1 -: 2];
            assign is_head       = (head_type == TYPE_HEAD) || (head_type == TYPE_HEADTAIL);
            assign is_last       = (head_type == TYPE_TAIL) || (head_type == TYPE_HEADTAIL);

            assign empty     = (count_reg == '0);
            assign full      = (count_reg == CNT_W'(BUFFER_SIZE));
            assign push      = valid_i[P] && (vc_id_i[P*VCW +: VCW] == VCW'(V));
            assign granted   = sw_grant_i[P] && (sw_vc_sel_i[P*VCW +: VCW] == VCW'(V));
            assign sw_pop[gi] = granted && (state_reg == ACTIVE) && !empty;
            assign bad_grant = granted && !((state_reg == ACTIVE) && !empty);
            // A non-head flit at the front of an idle VC can never be routed: drop it.
            assign discard   = (state_reg == IDLE) && !empty && !is_head;
            assign pop       = sw_pop[gi] || discard;
            assign push_ok   = push && (!full || pop);

            always_ff @(posedge clk) begin
                if (push_ok)
                    mem[wr_ptr_reg] <= flit_i[P*FLIT_WIDTH +: FLIT_WIDTH];
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    IDLE:    if (!empty && is_head) state_next = VA;
                    VA:      if (vc_grant_i[gi]) state_next = ACTIVE;
                    ACTIVE:  if (sw_pop[gi] && is_last) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg    <= IDLE;
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    out_port_reg <= '0;
                    dvc_reg      <= '0;
                    error_reg    <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    if (push_ok)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop);
                    if ((state_reg == IDLE) && (state_next == VA))
                        out_port_reg <= head_flit[gi][FLIT_WIDTH-3 -: 3];
                    if ((state_reg == VA) && vc_grant_i[gi])
                        dvc_reg <= vc_new_i[gi*VCW +: VCW];
                    error_reg <= error_reg | (push && !push_ok) | discard | bad_grant;
                end
            end

            assign vc_request_o[gi]             = (state_reg == VA);
            assign switch_request_o[gi]         = (state_reg == ACTIVE) && !empty;
            assign out_port_o[gi*3 +: 3]        = out_port_reg;
            assign downstream_vc_o[gi*VCW +: VCW] = dvc_reg;
            assign vc_allocatable_o[gi]         = (state_reg == IDLE) && empty;
            assign error_o[gi]                  = error_reg;

            if (CREDIT_MODE != 0) begin : g_pulse
                logic credit_reg;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)
                        credit_reg <= 1'b0;
                    else
                        credit_reg <= pop;
                end
                assign credit_o[gi] = credit_reg;
            end else begin : g_level
                assign credit_o[gi] = (CNT_W'(BUFFER_SIZE) - count_reg) > CNT_W'(ON_OFF_THRESHOLD);
            end
        end

        for (gi = 0; gi < PORT_NUM; gi++) begin : g_port
            logic [FLIT_WIDTH-1:0] sel_flit;
            logic                  any_pop;
            logic [FLIT_WIDTH-1:0] flit_reg;
            logic                  valid_reg;

            // At most one VC of a port pops per cycle, so an OR-style mux is enough.
            always_comb begin
                sel_flit = '0;
                for (int v = 0; v < VC_NUM; v++)
                    if (sw_pop[gi*VC_NUM + v])
                        sel_flit = head_flit[gi*VC_NUM + v];
            end
            assign any_pop = |sw_pop[gi*VC_NUM +: VC_NUM];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    flit_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= any_pop;
                    if (any_pop)
                        flit_reg <= sel_flit;
                end
            end

            assign flit_o[gi*FLIT_WIDTH +: FLIT_WIDTH] = flit_reg;
            assign flit_valid_o[gi]                    = valid_reg;
        end
    endgenerate
endmodule

// File: tb/tb_vc_input_block_v2.sv
// Directed bench for vc_input_block_v2: a credit-pulse instance (5 ports x 2 VCs)
// and an on/off instance (1 port x 2 VCs) sharing clock and reset.
module tb_vc_input_block_v2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // credit-pulse instance
    logic [319:0] flit_i;
    logic [4:0]   valid_i, vc_id_i, sw_grant_i, sw_vc_sel_i;
    logic [9:0]   vc_grant_i, vc_new_i;
    logic [319:0] flit_o;
    logic [4:0]   flit_valid_o;
    logic [9:0]   vc_request_o, switch_request_o, downstream_vc_o;
    logic [9:0]   credit_o, vc_allocatable_o, error_o;
    logic [29:0]  out_port_o;

    // on/off instance
    logic [63:0] m0_flit_i, m0_flit_o;
    logic [0:0]  m0_valid_i, m0_vc_id_i, m0_sw_grant_i, m0_sw_vc_sel_i, m0_flit_valid_o;
    logic [1:0]  m0_vc_grant_i, m0_vc_new_i, m0_vc_request_o, m0_switch_request_o;
    logic [1:0]  m0_downstream_vc_o, m0_credit_o, m0_vc_allocatable_o, m0_error_o;
    logic [5:0]  m0_out_port_o;

    vc_input_block_v2 #(.PORT_NUM(5), .VC_NUM(2), .BUFFER_SIZE(8), .FLIT_WIDTH(64),
                        .CREDIT_MODE(1), .ON_OFF_THRESHOLD(2)) dut (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .vc_id_i(vc_id_i),
        .vc_grant_i(vc_grant_i), .vc_new_i(vc_new_i), .sw_grant_i(sw_grant_i),
        .sw_vc_sel_i(sw_vc_sel_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o),
        .vc_request_o(vc_request_o), .switch_request_o(switch_request_o),
        .out_port_o(out_port_o), .downstream_vc_o(downstream_vc_o), .credit_o(credit_o),
        .vc_allocatable_o(vc_allocatable_o), .error_o(error_o)
    );

    vc_input_block_v2 #(.PORT_NUM(1), .VC_NUM(2), .BUFFER_SIZE(8), .FLIT_WIDTH(64),
                        .CREDIT_MODE(0), .ON_OFF_THRESHOLD(2)) dut_onoff (
        .clk(clk), .rst(rst), .flit_i(m0_flit_i), .valid_i(m0_valid_i), .vc_id_i(m0_vc_id_i),
        .vc_grant_i(m0_vc_grant_i), .vc_new_i(m0_vc_new_i), .sw_grant_i(m0_sw_grant_i),
        .sw_vc_sel_i(m0_sw_vc_sel_i), .flit_o(m0_flit_o), .flit_valid_o(m0_flit_valid_o),
        .vc_request_o(m0_vc_request_o), .switch_request_o(m0_switch_request_o),
        .out_port_o(m0_out_port_o), .downstream_vc_o(m0_downstream_vc_o),
        .credit_o(m0_credit_o), .vc_allocatable_o(m0_vc_allocatable_o), .error_o(m0_error_o)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp)
            checks_passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mk_flit(input logic [1:0] t, input logic [2:0] op,
                                            input logic [58:0] pl);
        return {t, op, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = '0; vc_grant_i = '0; sw_grant_i = '0;
        m0_valid_i = '0; m0_vc_grant_i = '0; m0_sw_grant_i = '0;
    endtask

    task automatic drive_push(input int p, input int v, input logic [63:0] f);
        valid_i[p]          = 1'b1;
        vc_id_i[p]          = v[0];
        flit_i[p*64 +: 64]  = f;
        $display("push port=%0d vc=%0d flit=%h", p, v, f);
    endtask

    task automatic push_one(input int p, input int v, input logic [63:0] f);
        drive_push(p, v, f);
        tick();
        idle_inputs();
    endtask

    task automatic sw_pop(input int p, input int v);
        sw_grant_i[p]  = 1'b1;
        sw_vc_sel_i[p] = v[0];
        $display("sw_grant port=%0d vc=%0d", p, v);
        tick();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [63:0] pk_flit [6];
    int          pk_vc   [6];
    int          pop_sel [6];
    logic [63:0] pop_exp [6];
    logic [1:0]  pop_alloc [6];
    logic [63:0] fx;

    initial begin
        flit_i = '0; vc_id_i = '0; vc_new_i = '0; sw_vc_sel_i = '0;
        m0_flit_i = '0; m0_vc_id_i = '0; m0_vc_new_i = '0; m0_sw_vc_sel_i = '0;
        idle_inputs();
        tick(); tick();

        // Reset values
        check_value("rst_flit_valid", flit_valid_o, 0);
        check_value("rst_flit_o", flit_o[63:0], 0);
        check_value("rst_vc_req", vc_request_o, 0);
        check_value("rst_sw_req", switch_request_o, 0);
        check_value("rst_credit", credit_o, 0);
        check_value("rst_alloc", vc_allocatable_o, 10'h3FF);
        check_value("rst_error", error_o, 0);
        check_value("rst_out_port", out_port_o, 0);
        check_value("rst_m0_credit", m0_credit_o, 2'b11);
        rst = 1'b1;
        tick();

        // Single headtail, port 0 VC1, out port 3
        fx = mk_flit(2'b11, 3'd3, 59'h0ABCDEF);
        push_one(0, 1, fx);
        check_value("ht_req_early", vc_request_o, 0);
        check_value("ht_alloc_busy", vc_allocatable_o[1], 0);
        tick();
        check_value("ht_vc_req", vc_request_o, 10'b10);
        check_value("ht_out_port", out_port_o[5:3], 3);
        vc_grant_i[1] = 1'b1; vc_new_i[1] = 1'b0;
        tick(); idle_inputs();
        check_value("ht_req_drop", vc_request_o, 0);
        check_value("ht_sw_req", switch_request_o, 10'b10);
        check_value("ht_dvc", downstream_vc_o[1], 0);
        sw_pop(0, 1);
        check_value("ht_flit_valid", flit_valid_o, 5'b00001);
        check_value("ht_flit", flit_o[63:0], fx);
        check_value("ht_credit", credit_o, 10'b10);
        check_value("ht_alloc", vc_allocatable_o[1], 1);
        tick();
        check_value("ht_credit_end", credit_o, 0);
        check_value("ht_valid_end", flit_valid_o[0], 0);

        // Interleaved packets on port 0: VC0 head/body/body/tail, VC1 head/tail
        pk_vc[0] = 0; pk_flit[0] = mk_flit(2'b00, 3'd2, 59'h100);
        pk_vc[1] = 1; pk_flit[1] = mk_flit(2'b00, 3'd4, 59'h200);
        pk_vc[2] = 0; pk_flit[2] = mk_flit(2'b01, 3'd0, 59'h101);
        pk_vc[3] = 1; pk_flit[3] = mk_flit(2'b10, 3'd0, 59'h201);
        pk_vc[4] = 0; pk_flit[4] = mk_flit(2'b01, 3'd0, 59'h102);
        pk_vc[5] = 0; pk_flit[5] = mk_flit(2'b10, 3'd0, 59'h103);
        for (int i = 0; i < 6; i++)
            push_one(0, pk_vc[i], pk_flit[i]);
        check_value("il_vc_req", vc_request_o[1:0], 2'b11);
        check_value("il_out0", out_port_o[2:0], 2);
        check_value("il_out1", out_port_o[5:3], 4);
        vc_grant_i[1:0] = 2'b11; vc_new_i[1:0] = 2'b01;
        tick(); idle_inputs();
        check_value("il_dvc", downstream_vc_o[1:0], 2'b01);
        check_value("il_sw_req", switch_request_o[1:0], 2'b11);
        pop_sel[0] = 1; pop_exp[0] = pk_flit[1]; pop_alloc[0] = 2'b00;
        pop_sel[1] = 0; pop_exp[1] = pk_flit[0]; pop_alloc[1] = 2'b00;
        pop_sel[2] = 0; pop_exp[2] = pk_flit[2]; pop_alloc[2] = 2'b00;
        pop_sel[3] = 1; pop_exp[3] = pk_flit[3]; pop_alloc[3] = 2'b10;
        pop_sel[4] = 0; pop_exp[4] = pk_flit[4]; pop_alloc[4] = 2'b10;
        pop_sel[5] = 0; pop_exp[5] = pk_flit[5]; pop_alloc[5] = 2'b11;
        for (int i = 0; i < 6; i++) begin
            sw_pop(0, pop_sel[i]);
            check_value($sformatf("il_flit%0d", i), flit_o[63:0], pop_exp[i]);
            check_value($sformatf("il_valid%0d", i), flit_valid_o[0], 1);
            check_value($sformatf("il_credit%0d", i), credit_o[1:0], (pop_sel[i] == 1) ? 2'b10 : 2'b01);
            check_value($sformatf("il_alloc%0d", i), vc_allocatable_o[1:0], pop_alloc[i]);
        end
        check_value("il_err", error_o, 0);

        // Overflow on port 1 VC0
        for (int i = 0; i < 9; i++) begin
            push_one(1, 0, mk_flit(2'b11, 3'd1, 59'(i)));
            if (i == 7) check_value("ovf_not_yet", error_o[3:2], 2'b00);
        end
        check_value("ovf_err", error_o[3:2], 2'b01);

        // Full VC with simultaneous push and pop: port 1 VC1
        fx = mk_flit(2'b00, 3'd5, 59'h300);
        push_one(1, 1, fx);
        for (int i = 1; i < 8; i++)
            push_one(1, 1, mk_flit(2'b01, 3'd0, 59'h300 + 59'(i)));
        vc_grant_i[3] = 1'b1; vc_new_i[3] = 1'b1;
        tick(); idle_inputs();
        check_value("full_dvc", downstream_vc_o[3], 1);
        check_value("full_sw_req", switch_request_o[3], 1);
        drive_push(1, 1, mk_flit(2'b01, 3'd0, 59'h3FF));
        sw_pop(1, 1);
        check_value("full_pp_err", error_o[3], 0);
        check_value("full_pp_valid", flit_valid_o[1], 1);
        check_value("full_pp_flit", flit_o[127:64], fx);
        push_one(1, 1, mk_flit(2'b10, 3'd0, 59'h3AA));
        check_value("full_still_full", error_o[3], 1);

        // Protocol errors: body into empty VC (port 2 VC0), grant to idle VC (port 3 VC1)
        push_one(2, 0, mk_flit(2'b01, 3'd0, 59'h555));
        check_value("body_err_early", error_o[4], 0);
        tick();
        check_value("body_err", error_o[4], 1);
        check_value("body_credit", credit_o[4], 1);
        check_value("body_alloc", vc_allocatable_o[4], 1);
        check_value("body_no_req", vc_request_o[4], 0);
        sw_pop(3, 1);
        check_value("idle_grant_err", error_o[7], 1);
        check_value("idle_grant_valid", flit_valid_o[3], 0);
        check_value("err_vector", error_o, 10'h09C);

        // On/off flow control: level drops at 6 occupied, back at 5
        for (int k = 1; k <= 6; k++) begin
            m0_valid_i = 1'b1; m0_vc_id_i = 1'b0;
            m0_flit_i = mk_flit((k == 1) ? 2'b00 : 2'b01, 3'd1, 59'(k));
            $display("push onoff vc=0 flit=%h", m0_flit_i);
            tick(); idle_inputs();
            check_value($sformatf("onoff_credit%0d", k), m0_credit_o[0], (k <= 5) ? 1'b1 : 1'b0);
        end
        check_value("onoff_other_vc", m0_credit_o[1], 1);
        m0_vc_grant_i[0] = 1'b1; m0_vc_new_i[0] = 1'b0;
        tick(); idle_inputs();
        check_value("onoff_hold", m0_credit_o[0], 0);
        m0_sw_grant_i = 1'b1; m0_sw_vc_sel_i = 1'b0;
        tick(); idle_inputs();
        check_value("onoff_rise", m0_credit_o[0], 1);
        check_value("onoff_flit", m0_flit_o, mk_flit(2'b00, 3'd1, 59'd1));

        // Reset mid-transfer on port 4 VC0
        fx = mk_flit(2'b11, 3'd1, 59'h444);
        push_one(4, 0, fx);
        tick();
        vc_grant_i[8] = 1'b1; vc_new_i[8] = 1'b1;
        tick(); idle_inputs();
        sw_pop(4, 0);
        check_value("mid_valid_pre", flit_valid_o[4], 1);
        check_value("mid_flit_pre", flit_o[319:256], fx);
        #2 rst = 1'b0;
        #1;
        check_value("mid_valid", flit_valid_o, 0);
        check_value("mid_flit", flit_o[319:256], 0);
        check_value("mid_err", error_o, 0);
        check_value("mid_alloc", vc_allocatable_o, 10'h3FF);
        check_value("mid_dvc", downstream_vc_o, 0);
        check_value("mid_sw_req", m0_switch_request_o, 0);
        check_value("mid_m0_credit", m0_credit_o, 2'b11);
        tick();
        check_value("mid_valid_hold", flit_valid_o, 0);
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
